mont_reduce: RTL and testbench

- Converts an operand out of the Montgomery domain: result = a * R^-1 mod n, with R = 2^WIDTH.
- It is the exit-side counterpart of the Montgomery multiplier, which maps operands into the domain (x*R mod n) before multiplying.
- It sits at the output of the RSA modular-exponentiation datapath and returns the final ciphertext/plaintext in normal representation.
- Bit-serial REDC: one right-shift iteration per clock, then one conditional-subtract cycle.

---
 rtl/rsa_pkg.sv | 13 +
 rtl/mont_redc_step.sv | 24 ++
 rtl/mont_reduce.sv | 113 +++++++++++
 tb/tb_mont_reduce.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Definitions shared across the RSA modular-exponentiation datapath:
// the default operand width and the control-state encoding.
package rsa_pkg;

    localparam int RSA_WIDTH = 2048;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } rsa_state_t;

endpackage

// File: rtl/mont_redc_step.sv
// One bit-serial REDC iteration: t_next = (t + (t odd ? nn : 0)) / 2.
// Purely combinational so it can be chained for an unrolled variant.
module mont_redc_step
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic [WIDTH:0]   t,
    input  logic [WIDTH-1:0] nn,
    output logic [WIDTH:0]   t_next
);

    logic [WIDTH-1:0] addend;

    // Halve both terms before adding; the dropped LSBs only contribute a carry.
    // This is equivalent to the WIDTH+2-bit sum shifted right by one.
    always_comb begin
        addend = t[0] ? nn : '0;
        t_next = {1'b0, t[WIDTH:1]}
               + {2'b00, addend[WIDTH-1:1]}
               + {{WIDTH{1'b0}}, t[0] & addend[0]};
    end

endmodule

// File: rtl/mont_reduce.sv
// Montgomery-domain exit: result = a * 2^-WIDTH mod n, computed one REDC
// iteration per clock followed by a single conditional subtract.
module mont_reduce
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    rsa_state_t       state_q, state_d;
    logic [WIDTH:0]   t_q, t_d, t_step;
    logic [WIDTH-1:0] nn_q, nn_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] t_sub;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    mont_redc_step #(.WIDTH(WIDTH)) u_step (
        .t      (t_q),
        .nn     (nn_q),
        .t_next (t_step)
    );

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        nn_d     = nn_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        result_d = result_q;
        // t <= n before FIX, so the low WIDTH bits of the difference are exact.
        t_sub    = t_q[WIDTH-1:0] - nn_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    t_d   = {1'b0, a};
                    nn_d  = n;
                    cnt_d = '0;
                    err_d = ~n[0];
                    if (n[0]) begin
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        result_d = '0;
                        done_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                t_d   = t_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = (t_q >= {1'b0, nn_q}) ? t_sub : t_q[WIDTH-1:0];
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            t_q      <= '0;
            nn_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            nn_q     <= nn_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_mont_reduce.sv
// Bench for mont_reduce: an 8-bit instance with a cycle-exact scoreboard and
// a 64-bit instance checked against a modular-inverse reference.
module tb_mont_reduce;

    localparam int W8  = 8;
    localparam int W64 = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        s8;
    logic [7:0]  a8, n8, res8;
    logic        busy8, done8, err8;
    logic        s64;
    logic [63:0] a64, n64, res64;
    logic        busy64, done64, err64;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          cyc = 0;
    int          idle_from = 0;

    always @(posedge clk) cyc <= cyc + 1;

    mont_reduce #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .n(n8),
        .busy(busy8), .done(done8), .err(err8), .result(res8)
    );

    mont_reduce #(.WIDTH(W64)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(s64), .a(a64), .n(n64),
        .busy(busy64), .done(done64), .err(err64), .result(res64)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // x such that x * 2^8 == a (mod n), found by search.
    function automatic logic [7:0] ref8(input int a, input int n);
        for (int x = 0; x < n; x++)
            if ((x * 256) % n == a % n) return 8'(x);
        return 8'h0;
    endfunction

    function automatic logic [63:0] mulmod(input logic [63:0] x, input logic [63:0] y,
                                           input logic [63:0] n);
        logic [127:0] p;
        p = {64'h0, x} * {64'h0, y};
        return 64'(p % {64'h0, n});
    endfunction

    // a * (2^-1)^64 mod n, with 2^-1 = (n+1)/2 for odd n.
    function automatic logic [63:0] ref64(input logic [63:0] a, input logic [63:0] n);
        logic [63:0] inv2, r;
        inv2 = (n >> 1) + 64'd1;
        r    = 64'd1 % n;
        for (int i = 0; i < 64; i++) r = mulmod(r, inv2, n);
        return mulmod(a % n, r, n);
    endfunction

    typedef struct {
        int         k;
        int         d;
        logic [7:0] res;
        logic       err;
    } exp_t;

    exp_t       q[$];
    logic [7:0] held_res = 8'h0;
    logic       held_err = 1'b0;

    // Every cycle: busy, done, result and err of the 8-bit DUT against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy8", busy8, 0);
            chk("rst_done8", done8, 0);
            chk("rst_result8", res8, 0);
            chk("rst_err8", err8, 0);
            q.delete();
            held_res = 8'h0;
            held_err = 1'b0;
        end else begin
            logic eb, ed;
            eb = (q.size() > 0) && (cyc >= q[0].k) && (cyc < q[0].d);
            ed = (q.size() > 0) && (cyc == q[0].d);
            if (q.size() > 0 && cyc >= q[0].k && !q[0].err) held_err = 1'b0;
            if (ed) begin
                held_res = q[0].res;
                held_err = q[0].err;
                void'(q.pop_front());
            end
            chk("busy8", busy8, 64'(eb));
            chk("done8", done8, 64'(ed));
            chk("result8", res8, 64'(held_res));
            chk("err8", err8, 64'(held_err));
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] n, input logic [7:0] res);
        exp_t e;
        @(negedge clk);
        while (cyc + 1 < idle_from) @(negedge clk);
        s8 = 1'b1;
        a8 = a;
        n8 = n;
        e.k = cyc + 1;
        if (n[0]) begin
            e.d = e.k + W8 + 1;
            e.res = res;
            e.err = 1'b0;
            idle_from = e.d + 1;
        end else begin
            e.d = e.k;
            e.res = 8'h0;
            e.err = 1'b1;
            idle_from = e.k + 1;
        end
        q.push_back(e);
    endtask

    task automatic drop8();
        @(negedge clk);
        s8 = 1'b0;
        a8 = 8'($urandom);
        n8 = 8'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          pa [3];
        int          pn [3];
        int          pr [3];
        logic [63:0] one, thirteen;
        logic [7:0]  ra, rn;
        logic [63:0] na, nb;
        int          lat, t0;

        rst_n = 1'b0;
        s8 = 1'b0; a8 = 8'h0; n8 = 8'h0;
        s64 = 1'b0; a64 = '0; n64 = '0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        pa = '{9, 255, 6};
        pn = '{13, 13, 13};
        pr = '{1, 11, 5};
        for (int i = 0; i < 3; i++) chk("model8_pin", ref8(pa[i], pn[i]), 64'(pr[i]));
        one = 64'd1;
        thirteen = 64'd13;
        chk("model64_pin", ref64(one, thirteen), 64'd9);

        issue8(8'd9, 8'd13, 8'd1);    drop8();
        issue8(8'd6, 8'd13, 8'd5);    drop8();
        issue8(8'd0, 8'd13, 8'd0);    drop8();
        issue8(8'd13, 8'd13, 8'd0);   drop8();
        issue8(8'd255, 8'd13, 8'd11); drop8();
        issue8(8'd9, 8'd12, 8'd0);    drop8();
        issue8(8'd9, 8'd13, 8'd1);    drop8();

        issue8(8'd9, 8'd13, 8'd1);    drop8();
        repeat (3) @(negedge clk);
        s8 = 1'b1; a8 = 8'd6; n8 = 8'd13;
        @(negedge clk);
        s8 = 1'b0;

        issue8(8'd9, 8'd13, 8'd1);    drop8();
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_busy8", busy8, 0);
        chk("async_rst_result8", res8, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_from = 0;
        issue8(8'd6, 8'd13, 8'd5);    drop8();

        issue8(8'd9, 8'd13, 8'd1);
        issue8(8'd6, 8'd13, 8'd5);
        drop8();

        for (int i = 0; i < 30; i++) begin
            rn = 8'($urandom_range(1, 255));
            if (i % 7 != 3) rn[0] = 1'b1;
            ra = 8'($urandom);
            if (i == 5) ra = 8'hff;
            if (i == 6) ra = rn;
            issue8(ra, rn, rn[0] ? ref8(int'(ra), int'(rn)) : 8'h0);
            drop8();
        end

        repeat (W8 + 4) @(negedge clk);
        chk("drain8", 64'(q.size()), 0);

        for (int i = 0; i < 40; i++) begin
            nb = {$urandom, $urandom};
            if (i % 4 == 0) nb[63] = 1'b1;
            nb[0] = (i != 7);
            na = {$urandom, $urandom};
            if (i == 1) na = '1;
            if (i == 2) na = nb;
            if (i == 3) na = '0;
            @(negedge clk);
            s64 = 1'b1; a64 = na; n64 = nb;
            t0 = cyc + 1;
            @(negedge clk);
            s64 = 1'b0; a64 = {$urandom, $urandom}; n64 = {$urandom, $urandom};
            lat = -1;
            for (int w = 0; w <= W64 + 4; w++) begin
                if (done64) begin
                    lat = cyc - t0;
                    break;
                end
                chk("busy64", busy64, 64'(nb[0]));
                @(negedge clk);
            end
            chk("latency64", 64'(lat), nb[0] ? 64'(W64 + 1) : 64'd0);
            chk("result64", res64, nb[0] ? ref64(na, nb) : 64'd0);
            chk("err64", err64, 64'(!nb[0]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
